// File: rtl/sgm_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
// Segment vectors are ordered {a,b,c,d,e,f,g}, bit 6 = a, and use logical
// polarity (1 = segment on).
package sgm_pkg;

   typedef logic [6:0] seg_t;

   localparam int MAX_DIGITS = 8;

   localparam seg_t SEG_0     = 7'b1111110;
   localparam seg_t SEG_1     = 7'b0110000;
   localparam seg_t SEG_2     = 7'b1101101;
   localparam seg_t SEG_3     = 7'b1111001;
   localparam seg_t SEG_4     = 7'b0110011;
   localparam seg_t SEG_5     = 7'b1011011;
   localparam seg_t SEG_6     = 7'b1011111;
   localparam seg_t SEG_7     = 7'b1110000;
   localparam seg_t SEG_8     = 7'b1111111;
   localparam seg_t SEG_9     = 7'b1111011;
   localparam seg_t SEG_A     = 7'b1110111;
   localparam seg_t SEG_B     = 7'b0011111;
   localparam seg_t SEG_C     = 7'b1001110;
   localparam seg_t SEG_D     = 7'b0111101;
   localparam seg_t SEG_E     = 7'b1001111;
   localparam seg_t SEG_F     = 7'b1000111;
   localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/sgm_decode.sv
// Combinational nibble to 7-segment decoder.
//   nib_i    : 4-bit code
//   hex_en_i : 1 = codes 10..15 render A,b,C,d,E,F; 0 = render blank
//   seg_o    : segments {a..g}, logical polarity
module sgm_decode
   import sgm_pkg::*;
(
   input  logic [3:0] nib_i,
   input  logic       hex_en_i,
   output seg_t       seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (nib_i)
         4'h0: seg_o = SEG_0;
         4'h1: seg_o = SEG_1;
         4'h2: seg_o = SEG_2;
         4'h3: seg_o = SEG_3;
         4'h4: seg_o = SEG_4;
         4'h5: seg_o = SEG_5;
         4'h6: seg_o = SEG_6;
         4'h7: seg_o = SEG_7;
         4'h8: seg_o = SEG_8;
         4'h9: seg_o = SEG_9;
         4'hA: seg_o = hex_en_i ? SEG_A : SEG_BLANK;
         4'hB: seg_o = hex_en_i ? SEG_B : SEG_BLANK;
         4'hC: seg_o = hex_en_i ? SEG_C : SEG_BLANK;
         4'hD: seg_o = hex_en_i ? SEG_D : SEG_BLANK;
         4'hE: seg_o = hex_en_i ? SEG_E : SEG_BLANK;
         4'hF: seg_o = hex_en_i ? SEG_F : SEG_BLANK;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sgm_scan_driver.sv
// Time-multiplexed driver for DIGITS 7-segment digits with a double-buffered
// value so a frame never shows a half-updated number.
//   clk_i        : system clock
//   rst_n_i      : asynchronous active-low reset
//   en_i         : 1 = scanning; 0 = dark, prescaler and slot index held
//   load_i       : one-cycle strobe capturing digits_in_i / dp_in_i
//   digits_in_i  : packed nibbles, digit 0 in bits [3:0]
//   dp_in_i      : decimal point per digit
//   sgm_o        : segments {a..g} of the lit digit
//   dp_o         : decimal point of the lit digit
//   an_o         : one-hot digit enable
//   frame_o      : one-cycle pulse on the first cycle of a new frame
module sgm_scan_driver
   import sgm_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int DIV        = 50000,
   parameter bit HEX_EN     = 1'b0,
   parameter bit BLANK_LZ   = 1'b1,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  en_i,
   input  logic                  load_i,
   input  logic [4*DIGITS-1:0]   digits_in_i,
   input  logic [DIGITS-1:0]     dp_in_i,
   output logic [6:0]            sgm_o,
   output logic                  dp_o,
   output logic [DIGITS-1:0]     an_o,
   output logic                  frame_o
);

   localparam int PW = $clog2(DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*DIGITS-1:0]   pend_q, pend_d, disp_q, disp_d;
   logic [DIGITS-1:0]     pdp_q, pdp_d, ddp_q, ddp_d;
   seg_t                  seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic                  frame_q, frame_d;

   logic                  tick, wrap;
   logic [3:0]            nib;
   logic                  nib_dp;
   logic                  blank;
   seg_t                  dec_seg;

   always_comb begin
      tick    = en_i && (presc_q == PRESC_LAST);
      wrap    = tick && (idx_q == IDX_LAST);
      presc_d = presc_q;
      idx_d   = idx_q;
      if (en_i) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
         if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
      end
   end

   // Display only changes at the frame boundary; while dark it tracks pending
   // so resuming picks up the latest value without waiting a whole frame.
   always_comb begin
      pend_d = load_i ? digits_in_i : pend_q;
      pdp_d  = load_i ? dp_in_i     : pdp_q;
      disp_d = disp_q;
      ddp_d  = ddp_q;
      if (!en_i) begin
         disp_d = pend_q;
         ddp_d  = pdp_q;
      end else if (wrap) begin
         disp_d = load_i ? digits_in_i : pend_q;
         ddp_d  = load_i ? dp_in_i     : pdp_q;
      end
   end

   // Digit mux; a digit above 0 is a leading zero when it and everything
   // above it is zero.
   always_comb begin
      nib    = '0;
      nib_dp = 1'b0;
      blank  = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            nib    = disp_q[4*k +: 4];
            nib_dp = ddp_q[k];
            blank  = (k != 0) && ((disp_q >> (4*k)) == '0);
         end
      end
   end

   sgm_decode u_decode (
      .nib_i    (nib),
      .hex_en_i (HEX_EN),
      .seg_o    (dec_seg)
   );

   always_comb begin
      seg_d   = SEG_BLANK;
      dp_d    = 1'b0;
      an_d    = '0;
      frame_d = 1'b0;
      if (en_i) begin
         seg_d   = (BLANK_LZ && blank) ? SEG_BLANK : dec_seg;
         dp_d    = nib_dp;
         an_d    = DIGITS'(1) << idx_q;
         frame_d = (idx_q == '0) && (presc_q == '0);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         presc_q <= '0;
         idx_q   <= '0;
         pend_q  <= '0;
         pdp_q   <= '0;
         disp_q  <= '0;
         ddp_q   <= '0;
         seg_q   <= SEG_BLANK;
         dp_q    <= 1'b0;
         an_q    <= '0;
         frame_q <= 1'b0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         pdp_q   <= pdp_d;
         disp_q  <= disp_d;
         ddp_q   <= ddp_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         an_q    <= an_d;
         frame_q <= frame_d;
      end
   end

   // Pin polarity applied after the registers so reset drives pins inactive.
   assign sgm_o   = seg_q ^ {7{ACTIVE_LOW}};
   assign dp_o    = dp_q ^ ACTIVE_LOW;
   assign an_o    = an_q ^ {DIGITS{ACTIVE_LOW}};
   assign frame_o = frame_q;

endmodule

// File: tb/tb_sgm_scan_driver.sv
// Scoreboard bench: two driver instances (plain/LZ-blank/no-hex and
// inverted/hex/no-blank) share stimulus; a frame-position model predicts each
// cycle's pins and a monitor compares after every rising edge.
module tb_sgm_scan_driver;

   localparam int DG = 4;
   localparam int DV = 4;
   localparam int FL = DG * DV;

   typedef struct packed {
      logic [6:0] sgm;
      logic       dp;
      logic [3:0] an;
      logic       frame;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [15:0] din = '0;
   logic [3:0]  dpin = '0;

   logic [6:0]  sgm_a, sgm_b;
   logic        dp_a, dp_b, frame_a, frame_b;
   logic [3:0]  an_a, an_b;

   int checks = 0;
   int failures = 0;

   obs_t qa[$];
   obs_t qb[$];

   int          m_pos = 0;
   logic [15:0] m_pend = '0, m_disp = '0;
   logic [3:0]  m_pdp = '0, m_ddp = '0;

   always #5 clk = ~clk;

   sgm_scan_driver #(.DIGITS(DG), .DIV(DV), .HEX_EN(1'b0), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b0)) dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .load_i(load),
      .digits_in_i(din), .dp_in_i(dpin),
      .sgm_o(sgm_a), .dp_o(dp_a), .an_o(an_a), .frame_o(frame_a));

   sgm_scan_driver #(.DIGITS(DG), .DIV(DV), .HEX_EN(1'b1), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b1)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .load_i(load),
      .digits_in_i(din), .dp_in_i(dpin),
      .sgm_o(sgm_b), .dp_o(dp_b), .an_o(an_b), .frame_o(frame_b));

   function automatic logic [6:0] seg_of(input logic [3:0] c, input bit hex);
      logic [6:0] s;
      case (c)
         4'h0: s = 7'b1111110;  4'h1: s = 7'b0110000;
         4'h2: s = 7'b1101101;  4'h3: s = 7'b1111001;
         4'h4: s = 7'b0110011;  4'h5: s = 7'b1011011;
         4'h6: s = 7'b1011111;  4'h7: s = 7'b1110000;
         4'h8: s = 7'b1111111;  4'h9: s = 7'b1111011;
         4'hA: s = 7'b1110111;  4'hB: s = 7'b0011111;
         4'hC: s = 7'b1001110;  4'hD: s = 7'b0111101;
         4'hE: s = 7'b1001111;  default: s = 7'b1000111;
      endcase
      if (!hex && c > 4'd9) s = 7'b0000000;
      return s;
   endfunction

   // Pins expected after the coming edge, from the model's current position.
   function automatic obs_t expect_out(input bit hex, input bit blz, input bit al, input bit e);
      obs_t o;
      int   k;
      o = '0;
      if (e) begin
         k       = m_pos / DV;
         o.sgm   = seg_of(4'((m_disp >> (4*k)) & 16'hF), hex);
         if (blz && k > 0 && (m_disp >> (4*k)) == 16'h0) o.sgm = 7'b0;
         o.dp    = m_ddp[k];
         o.an    = 4'(1 << k);
         o.frame = (m_pos == 0);
      end
      if (al) begin
         o.sgm = ~o.sgm;
         o.dp  = ~o.dp;
         o.an  = ~o.an;
      end
      return o;
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t: got sgm=%b dp=%b an=%b frame=%b, expected sgm=%b dp=%b an=%b frame=%b",
                  name, $time, act.sgm, act.dp, act.an, act.frame, exp.sgm, exp.dp, exp.an, exp.frame);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (qa.size() > 0) begin
         check("scan_a", {sgm_a, dp_a, an_a, frame_a}, qa.pop_front());
         check("scan_b", {sgm_b, dp_b, an_b, frame_b}, qb.pop_front());
      end
   end

   task automatic step(input bit e, input bit l, input logic [15:0] d, input logic [3:0] p);
      @(negedge clk);
      en = e; load = l; din = d; dpin = p;
      qa.push_back(expect_out(1'b0, 1'b1, 1'b0, e));
      qb.push_back(expect_out(1'b1, 1'b0, 1'b1, e));
      if (e) begin
         if (m_pos == FL - 1) begin
            m_disp = l ? d : m_pend;
            m_ddp  = l ? p : m_pdp;
         end
         m_pos = (m_pos + 1) % FL;
      end else begin
         m_disp = m_pend;
         m_ddp  = m_pdp;
      end
      if (l) begin
         m_pend = d;
         m_pdp  = p;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, din, dpin);
   endtask

   task automatic goto_pos(input int p);
      for (int i = 0; i < FL && m_pos != p; i++) step(1'b1, 1'b0, din, dpin);
   endtask

   task automatic model_clear();
      m_pos = 0; m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0;
   endtask

   task automatic check_dark(input string name);
      check({name, "_a"}, {sgm_a, dp_a, an_a, frame_a}, '0);
      check({name, "_b"}, {sgm_b, dp_b, an_b, frame_b}, {7'h7F, 1'b1, 4'hF, 1'b0});
   endtask

   task automatic async_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_dark("async_rst");
      model_clear();
      en = 1'b0; load = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 check_dark("post_rst");
   endtask

   initial begin
      rst_n = 1'b0;
      #2 check_dark("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1 check_dark("release");

      // 0x1234 appears from the second frame on
      step(1'b1, 1'b1, 16'h1234, 4'b0000);
      run(2*FL + 2);

      // leading-zero blanking
      step(1'b1, 1'b1, 16'h0070, 4'b0000);
      run(2*FL);
      step(1'b1, 1'b1, 16'h0000, 4'b0100);
      run(2*FL);

      // hex vs blank rendering, with decimal points
      step(1'b1, 1'b1, 16'hABCD, 4'b0101);
      run(2*FL);

      // mid-frame load waits for the frame start; wrap-tick load bypasses
      step(1'b1, 1'b1, 16'h1234, 4'b0000);
      run(2*FL);
      goto_pos(5);
      step(1'b1, 1'b1, 16'h5555, 4'b1000);
      run(2*FL);
      goto_pos(FL - 1);
      step(1'b1, 1'b1, 16'h9876, 4'b0010);
      run(FL + 3);

      // pause mid-slot, then resume in the same digit
      goto_pos(6);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, din, dpin);
      run(2*FL);

      // asynchronous reset mid-slot with a pending value outstanding
      step(1'b1, 1'b1, 16'h4321, 4'b1111);
      goto_pos(9);
      async_reset();
      run(2*FL);

      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
              16'($urandom), 4'($urandom));
      end
      step(1'b1, 1'b0, din, dpin);
      @(posedge clk);
      #3;
      if (qa.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: got %0d pending expectations, expected 0", qa.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sgm_scan_driver.md
# sgm_scan_driver

Time-multiplexed driver for a bank of DIGITS common-anode/common-cathode 7-segment digits. Accepts a packed BCD/hex value, double-buffers it so updates never tear mid-frame, scans one digit per slot at a programmable rate, and drives shared segment lines plus one enable line per digit. Successor to the single-digit BCD segment decoder; sits between the datapath result registers and the board display pins.

## Interface
- DIGITS, 4: number of digits scanned (1..8).
- DIV, 50000: clock cycles each digit is lit (slot length, ≥2).
- HEX_EN, 0: 1 = codes 10..15 render A,b,C,d,E,F; 0 = render blank.
- BLANK_LZ, 1: 1 = suppress leading zeros; digit 0 (least significant) is never suppressed.
- ACTIVE_LOW, 0: 1 = invert sgm, dp and an at the pins.

- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- en  in  1  1 = scanning; 0 = all digits dark, prescaler and slot index held.
- load  in  1  one-cycle strobe capturing digits_in/dp_in.
- digits_in  in  4*DIGITS  nibble k = digit k, digit 0 in bits [3:0].
- dp_in  in  DIGITS  decimal point per digit.
- sgm  out  7  segments {a,b,c,d,e,f,g}, bit 6 = a.
- dp  out  1  decimal point of lit digit.
- an  out  DIGITS  one-hot digit enable, bit k = digit k.
- frame  out  1  one-cycle pulse marking start of a new frame.

## Operation
- Logical polarity: 1 = segment/digit on; ACTIVE_LOW inverts all three outputs after registering.
- Prescaler counts 0..DIV-1 while en=1; tick when count = DIV-1, count wraps to 0.
- Slot index 0..DIGITS-1 advances on tick; wraps DIGITS-1 -> 0 ("wrap tick").
- Pending buffer: load=1 copies digits_in/dp_in into pending, independent of en; last load wins.
- Display buffer: on wrap tick, display <= (load ? inputs : pending). While en=0, display <= pending every cycle (display is dark, no tearing).
- Decode: 0..9 -> 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011; 10..15 with HEX_EN -> 1110111, 0011111, 1001110, 0111101, 1001111, 1000111; otherwise 0000000.
- Leading-zero blank: with BLANK_LZ, digit k>0 shows sgm=0 if it and all higher digits are 0; dp unaffected.
- en=0: an=0, sgm=0, dp=0 (logical); index and prescaler freeze, resume from held values.

## Timing
- Reset (asynchronous): prescaler 0, index 0, pending/display 0, frame 0, an/sgm/dp logical 0.
- sgm, dp, an, frame are registered: they reflect the slot index of the previous cycle (1-cycle latency).
- First cycle after rst_n deasserts with en=1: outputs still dark; next cycle an=0001.
- Each digit lit exactly DIV consecutive cycles; full frame = DIGITS*DIV cycles.
- frame high for exactly one cycle, coincident with the first cycle digit 0 is shown with the newly transferred display buffer.
- load on a wrap tick: new value shown from that frame start (bypass). load elsewhere: shown from next frame start.
- Reset mid-frame: immediate dark outputs, pending value discarded.

## Structure
- Package sgm_pkg: 7-bit segment constants for 0..F and blank, segment type, DIGITS upper bound.
- Sub-module sgm_decode (combinational nibble + hex_en -> 7 segments), one instance on the muxed nibble.
- Top holds prescaler, index, pending/display buffers, blanking logic, output registers.

## Test plan
- DIGITS=4, DIV=4: reset, en=1, load 0x1234 -> after first frame, an cycles 0001,0010,0100,1000 each 4 cycles; sgm 0110011,1111001,1101101,0110000 respectively... sequence matches digits 4,3,2,1 for an 0001..1000; frame every 16 cycles.
- Load 0x0070, BLANK_LZ=1 -> digits 3,2 sgm=0000000, digit 1 = 1110000, digit 0 = 1111110; load 0x0000 -> only digit 0 lit as 1111110.
- HEX_EN=0 vs 1, load 0xABCD -> blanks vs 1110111/0011111/1001110/0111101.
- Load 0x5555 mid-frame while showing 0x1234 -> remaining slots of current frame show 1234, next frame (frame pulse) shows 5555; load on wrap tick -> immediate.
- en=0 for 10 cycles mid-slot -> all outputs dark, index held; en=1 -> same digit resumes with remaining slot cycles; ACTIVE_LOW=1 -> all outputs inverted, reset gives an=1111.
- Assert rst_n=0 asynchronously mid-slot -> outputs dark same cycle, pending cleared, restart at digit 0.
